// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button front-end.
package btn_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      REPEATING    = 3'd3,
      RELEASE_WAIT = 3'd4
   } btn_state_t;

endpackage

// File: rtl/btn_input_ctrl_if.sv
// Button event port: one event (id + repeat flag) per valid/ready handshake.
interface btn_input_ctrl_if #(
   parameter int ID_W = 3
);
   // An event transfers on a clk edge where evt_valid && evt_ready. While
   // evt_valid is high and evt_ready low, evt_id and evt_repeat stay stable and
   // evt_valid does not drop; evt_ready may change freely.
   logic            evt_valid;
   logic            evt_ready;
   logic [ID_W-1:0] evt_id;
   logic            evt_repeat;

   modport master (
      output evt_valid,
      output evt_id,
      output evt_repeat,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      input  evt_repeat,
      output evt_ready
   );
endinterface

// File: rtl/btn_debounce_fsm.sv
// One button: two-flop synchronizer followed by a tick-driven debounce and
// hold-to-repeat FSM. Events are combinational pulses on the transition edge.
module btn_debounce_fsm
   import btn_pkg::*;
#(
   parameter int DEB_TICKS  = 4,
   parameter int HOLD_TICKS = 500,
   parameter int RPT_TICKS  = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       btn_raw,
   output logic       level,
   output logic       press_evt,
   output logic       rpt_evt,
   output btn_state_t state
);

   logic             meta;
   logic             btn_sync;
   btn_state_t       state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;

   localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB_TICKS);
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] RPT_C  = CNT_W'(RPT_TICKS);

   always_ff @(posedge clk) begin
      meta     <= btn_raw;
      btn_sync <= meta;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      press_evt = 1'b0;
      rpt_evt   = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               // cnt is always 0 here, so cnt_inc is the first qualifying tick
               if (btn_sync) begin
                  if (cnt_inc == DEB_C) begin
                     state_nxt = HELD;
                     cnt_nxt   = '0;
                     press_evt = 1'b1;
                  end else begin
                     state_nxt = PRESS_WAIT;
                     cnt_nxt   = cnt_inc;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!btn_sync) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt_inc == DEB_C) begin
                  state_nxt = HELD;
                  cnt_nxt   = '0;
                  press_evt = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            HELD, REPEATING: begin
               if (!btn_sync) begin
                  if (DEB_C == CNT_W'(1)) begin
                     state_nxt = IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = RELEASE_WAIT;
                     cnt_nxt   = CNT_W'(1);
                  end
               end else if (cnt_inc == ((state_q == HELD) ? HOLD_C : RPT_C)) begin
                  state_nxt = REPEATING;
                  cnt_nxt   = '0;
                  rpt_evt   = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            RELEASE_WAIT: begin
               // a bounce back high restarts the hold timing from scratch
               if (btn_sync) begin
                  state_nxt = HELD;
                  cnt_nxt   = '0;
               end else if (cnt_inc == DEB_C) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign level = (state_q == HELD) || (state_q == REPEATING) || (state_q == RELEASE_WAIT);
   assign state = state_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// Push-button front-end: per-button debounce FSMs feeding a lowest-index-first
// arbiter with one pending slot per button and a registered event port.
module btn_input_ctrl
   import btn_pkg::*;
#(
   parameter int N_BTN      = 5,
   parameter int DEB_TICKS  = 4,
   parameter int HOLD_TICKS = 500,
   parameter int RPT_TICKS  = 100,
   parameter int ID_W       = $clog2(N_BTN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic [N_BTN-1:0]      btn_raw,
   output logic [N_BTN-1:0]      btn_level,
   btn_input_ctrl_if.master      evt,
   output logic                  evt_overflow,
   output logic [N_BTN-1:0][2:0] fsm_state
);

   logic [N_BTN-1:0] press_evt;
   logic [N_BTN-1:0] rpt_evt;
   logic [N_BTN-1:0] new_evt;
   logic [N_BTN-1:0] pending_q, pending_nxt;
   logic [N_BTN-1:0] pend_rpt_q, pend_rpt_nxt;
   logic [N_BTN-1:0] take;
   logic [N_BTN-1:0] drop;
   logic             win_any;
   logic [ID_W-1:0]  win_id;
   logic             load;
   logic             valid_q;
   logic [ID_W-1:0]  id_q;
   logic             repeat_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_state_t st;
      btn_debounce_fsm #(
         .DEB_TICKS  (DEB_TICKS),
         .HOLD_TICKS (HOLD_TICKS),
         .RPT_TICKS  (RPT_TICKS)
      ) u_fsm (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick      (tick),
         .btn_raw   (btn_raw[i]),
         .level     (btn_level[i]),
         .press_evt (press_evt[i]),
         .rpt_evt   (rpt_evt[i]),
         .state     (st)
      );
      assign fsm_state[i] = st;
   end

   assign new_evt = press_evt | rpt_evt;
   assign load    = !valid_q || evt.evt_ready;

   always_comb begin
      win_any = 1'b0;
      win_id  = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            win_any = 1'b1;
            win_id  = ID_W'(i);
         end
      end
   end

   // A slot being loaded this cycle is free again, so an event landing on it
   // is kept rather than counted as an overflow.
   always_comb begin
      take         = '0;
      drop         = '0;
      pending_nxt  = pending_q;
      pend_rpt_nxt = pend_rpt_q;
      if (load && win_any) begin
         take[win_id] = 1'b1;
      end
      for (int i = 0; i < N_BTN; i++) begin
         if (new_evt[i] && (!pending_q[i] || take[i])) begin
            pending_nxt[i]  = 1'b1;
            pend_rpt_nxt[i] = rpt_evt[i];
         end else if (take[i]) begin
            pending_nxt[i] = 1'b0;
         end
         drop[i] = new_evt[i] && pending_q[i] && !take[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q    <= '0;
         pend_rpt_q   <= '0;
         valid_q      <= 1'b0;
         id_q         <= '0;
         repeat_q     <= 1'b0;
         evt_overflow <= 1'b0;
      end else begin
         pending_q    <= pending_nxt;
         pend_rpt_q   <= pend_rpt_nxt;
         evt_overflow <= evt_overflow | (|drop);
         if (load) begin
            valid_q <= win_any;
            if (win_any) begin
               id_q     <= win_id;
               repeat_q <= pend_rpt_q[win_id];
            end
         end
      end
   end

   assign evt.evt_valid  = valid_q;
   assign evt.evt_id     = id_q;
   assign evt.evt_repeat = repeat_q;

endmodule

// File: doc/btn_input_ctrl.md
# btn_input_ctrl

Push-button front-end controller for the alarm clock's setting buttons. Each raw button passes through a two-flop synchronizer, then a tick-based debounce FSM. The FSM produces a clean level, a press pulse and hold-to-repeat pulses. A lowest-index-first arbiter queues the resulting events onto a single valid/ready event port, which feeds the time/alarm setting logic.

## Interface
Parameters:
- N_BTN, 5: number of buttons (2..8).
- DEB_TICKS, 4: consecutive stable ticks required to accept a level change (1..255).
- HOLD_TICKS, 500: ticks held before the first repeat (2..65535).
- RPT_TICKS, 100: ticks between subsequent repeats (1..65535).
- ID_W, $clog2(N_BTN): width of the event id.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- tick  in  1  one-cycle timebase strobe, nominally 1 kHz.
- btn_raw  in  N_BTN  asynchronous button inputs, active-high.
- btn_level  out  N_BTN  debounced button levels.
- evt_valid  out  1  event available.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_repeat  out  1  0 = initial press, 1 = auto-repeat.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_overflow  out  1  sticky flag; an event was dropped.

## Operation
- Per button, a two-flop synchronizer produces btn_sync. No reset on the synchronizer flops.
- Per-button FSM, 16-bit tick counter cnt:
  - IDLE: level 0. On a tick with btn_sync=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: on each tick with btn_sync=1, cnt++. On a tick with btn_sync=0, return to IDLE. When cnt reaches DEB_TICKS on a tick, go to HELD, set level=1, raise a press event, and clear cnt.
  - HELD: level 1. Each tick, cnt++. At HOLD_TICKS, raise a repeat event, go to REPEATING, and clear cnt. A tick with btn_sync=0 goes to RELEASE_WAIT with cnt=1.
  - REPEATING: same as HELD, but the period is RPT_TICKS and each expiry raises a repeat event. A tick with btn_sync=0 goes to RELEASE_WAIT.
  - RELEASE_WAIT: on each tick with btn_sync=0, cnt++. When cnt reaches DEB_TICKS, set level=0, go to IDLE, raise no event. A tick with btn_sync=1 returns to HELD with cnt cleared, so the hold timing restarts.
- With DEB_TICKS=1, the transition happens on the first qualifying tick.
- Between ticks, the FSMs hold state. btn_sync changes are only evaluated on a tick.
- Arbiter:
  - Per-button pending bit, plus a pending_repeat bit.
  - A new event sets pending. If pending is already set and that event is not being accepted this cycle, the new event is dropped and evt_overflow is set.
  - The lowest-index pending button is presented on the output.
- Output register:
  - When evt_valid=0, or evt_valid && evt_ready, the register loads the winner on the next cycle and clears its pending bit.
  - evt_id, evt_repeat and evt_valid are held stable while evt_valid && !evt_ready.
- evt_overflow clears only on reset.

## Timing
- Reset values:
  - btn_level = 0, evt_valid = 0, evt_id = 0, evt_repeat = 0, evt_overflow = 0.
  - All FSMs in IDLE, all pending bits 0, all cnt = 0.
- Synchronizer latency: 2 clk.
- Press-to-level latency: 2 clk plus DEB_TICKS ticks. btn_level rises on the clk edge of the DEB_TICKS-th qualifying tick.
- Event latency:
  - The pending bit is set on the same edge that btn_level changes.
  - With no contention, evt_valid rises 1 clk later, giving 1 event per clk of throughput.
- Simultaneous events on several buttons: all become pending, and are emitted in index order on consecutive accepted cycles.
- Event raised on the same edge its own pending bit is cleared by a load: the event is kept pending and no overflow is flagged.
- Reset mid-operation takes priority over tick and handshake. All state returns to reset values in 1 clk, and pending events are discarded.

## Structure
- Shared package btn_pkg: FSM state enum (IDLE, PRESS_WAIT, HELD, REPEATING, RELEASE_WAIT) and the counter width constant CNT_W=16.
- Sub-module btn_debounce_fsm, one instance per button via generate. It contains the synchronizer and FSM and outputs level, press_evt and rpt_evt.
- Arbiter, pending bits and output register live in btn_input_ctrl.

## Test plan
- Reset: hold rst_n=0 with btn_raw=5'b11111 and ticks running, then release → all outputs 0, and btn_level goes 1 only after 4 more ticks.
- Bounce: with DEB_TICKS=4, toggle btn_raw[2] high for 3 ticks, low for 1, then high for 4 → a single event, evt_id=2, evt_repeat=0. btn_level[2] rises on the 4th stable tick.
- Auto-repeat: HOLD_TICKS=10, RPT_TICKS=3, hold btn 0 for 20 ticks after debounce → press event, repeat at tick 10, then repeats at ticks 13, 16 and 19. Release → no event, and level falls after 4 ticks.
- Arbitration: press buttons 4, 1 and 3 in the same cycle, evt_ready=1 → events emitted as id 1, 3, 4 on consecutive cycles.
- Backpressure/overflow: evt_ready=0, HOLD_TICKS=2, RPT_TICKS=1, hold btn 0 → the first event is held stable. A later event on btn 0 finds its pending bit set and is dropped, so evt_overflow=1 and stays 1 after evt_ready is raised.
- Reset mid-operation: assert rst_n=0 for 1 clk while evt_valid=1 and two events are pending → evt_valid=0 next cycle, and no stale events appear after release.
